// File: rtl/normalizer_arbiter_if.sv
// rtl/normalizer_arbiter_if.sv - requester A/B and result channel bundle for normalizer_arbiter
interface normalizer_arbiter_if #(
    parameter int TAG_WIDTH = 4
);
    logic                 a_valid;
    logic                 a_ready;
    logic [9:0]           a_exponent;
    logic [48:0]          a_fraction;
    logic [TAG_WIDTH-1:0] a_tag;

    logic                 b_valid;
    logic                 b_ready;
    logic [9:0]           b_exponent;
    logic [48:0]          b_fraction;
    logic [TAG_WIDTH-1:0] b_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [9:0]           out_exponent;
    logic [48:0]          out_fraction;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 out_source;

    modport slave (
        input  a_valid, a_exponent, a_fraction, a_tag,
        output a_ready,
        input  b_valid, b_exponent, b_fraction, b_tag,
        output b_ready,
        output out_valid, out_exponent, out_fraction, out_tag, out_source,
        input  out_ready
    );

    modport master (
        output a_valid, a_exponent, a_fraction, a_tag,
        input  a_ready,
        output b_valid, b_exponent, b_fraction, b_tag,
        input  b_ready,
        input  out_valid, out_exponent, out_fraction, out_tag, out_source,
        output out_ready
    );
endinterface

// File: rtl/normalizer_arbiter.sv
// rtl/normalizer_arbiter.sv - round-robin share of one normalizer between two requesters, 2-stage pipe
module normalizer_arbiter #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    normalizer_arbiter_if.slave   bus
);
    logic                 s1_valid_q, s1_valid_d;
    logic [9:0]           s1_exponent_q, s1_exponent_d;
    logic [48:0]          s1_fraction_q, s1_fraction_d;
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic                 s1_source_q, s1_source_d;

    logic                 out_valid_q, out_valid_d;
    logic [9:0]           out_exponent_q, out_exponent_d;
    logic [48:0]          out_fraction_q, out_fraction_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
    logic                 out_source_q, out_source_d;

    logic                 last_grant_q, last_grant_d;

    logic                 grant_a, grant_b;
    logic                 s2_advance, s1_accept;
    logic                 take_a, take_b;
    logic [4:0]           lzc;
    logic [9:0]           norm_exponent;
    logic [48:0]          norm_fraction;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant_a    = bus.a_valid && (!bus.b_valid || last_grant_q);
        grant_b    = bus.b_valid && (!bus.a_valid || !last_grant_q);
        s2_advance = !out_valid_q || bus.out_ready;
        s1_accept  = !s1_valid_q || s2_advance;
        take_a     = s1_accept && grant_a;
        take_b     = s1_accept && grant_b;
    end

    assign bus.a_ready = take_a;
    assign bus.b_ready = take_b;

    // An all-zero window counts as 24 leading zeros.
    always_comb begin
        lzc = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (s1_fraction_q[24 + i]) begin
                lzc = 5'(23 - i);
            end
        end
        if (s1_fraction_q[48]) begin
            norm_fraction = s1_fraction_q >> 1;
            norm_exponent = s1_exponent_q + 10'd1;
        end else if (s1_fraction_q[47]) begin
            norm_fraction = s1_fraction_q;
            norm_exponent = s1_exponent_q;
        end else begin
            norm_fraction = s1_fraction_q << lzc;
            norm_exponent = s1_exponent_q - {5'd0, lzc};
        end
    end

    always_comb begin
        last_grant_d   = last_grant_q;
        s1_valid_d     = s1_valid_q;
        s1_exponent_d  = s1_exponent_q;
        s1_fraction_d  = s1_fraction_q;
        s1_tag_d       = s1_tag_q;
        s1_source_d    = s1_source_q;
        out_valid_d    = out_valid_q;
        out_exponent_d = out_exponent_q;
        out_fraction_d = out_fraction_q;
        out_tag_d      = out_tag_q;
        out_source_d   = out_source_q;

        if (take_a) begin
            last_grant_d = 1'b0;
        end else if (take_b) begin
            last_grant_d = 1'b1;
        end

        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_exponent_d = norm_exponent;
                out_fraction_d = norm_fraction;
                out_tag_d      = s1_tag_q;
                out_source_d   = s1_source_q;
            end
        end

        if (s1_accept) begin
            s1_valid_d = take_a || take_b;
            if (take_a) begin
                s1_exponent_d = bus.a_exponent;
                s1_fraction_d = bus.a_fraction;
                s1_tag_d      = bus.a_tag;
                s1_source_d   = 1'b0;
            end else if (take_b) begin
                s1_exponent_d = bus.b_exponent;
                s1_fraction_d = bus.b_fraction;
                s1_tag_d      = bus.b_tag;
                s1_source_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q   <= 1'b1;
            s1_valid_q     <= 1'b0;
            s1_exponent_q  <= '0;
            s1_fraction_q  <= '0;
            s1_tag_q       <= '0;
            s1_source_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            out_exponent_q <= '0;
            out_fraction_q <= '0;
            out_tag_q      <= '0;
            out_source_q   <= 1'b0;
        end else begin
            last_grant_q   <= last_grant_d;
            s1_valid_q     <= s1_valid_d;
            s1_exponent_q  <= s1_exponent_d;
            s1_fraction_q  <= s1_fraction_d;
            s1_tag_q       <= s1_tag_d;
            s1_source_q    <= s1_source_d;
            out_valid_q    <= out_valid_d;
            out_exponent_q <= out_exponent_d;
            out_fraction_q <= out_fraction_d;
            out_tag_q      <= out_tag_d;
            out_source_q   <= out_source_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_exponent = out_exponent_q;
    assign bus.out_fraction = out_fraction_q;
    assign bus.out_tag      = out_tag_q;
    assign bus.out_source   = out_source_q;
endmodule

// File: tb/tb_normalizer_arbiter.sv
// tb/tb_normalizer_arbiter.sv - directed self-checking bench for normalizer_arbiter
module tb_normalizer_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    normalizer_arbiter_if #(.TAG_WIDTH(4)) bus ();

    normalizer_arbiter #(.TAG_WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_single(input string name, input bit src, input logic [9:0] e,
                              input logic [48:0] f, input logic [3:0] t,
                              input logic [9:0] ee, input logic [48:0] ef);
        if (src) begin
            bus.b_valid = 1'b1; bus.b_exponent = e; bus.b_fraction = f; bus.b_tag = t;
        end else begin
            bus.a_valid = 1'b1; bus.a_exponent = e; bus.a_fraction = f; bus.a_tag = t;
        end
        @(negedge clk);
        check_eq({name, "_ready"}, src ? bus.b_ready : bus.a_ready, 1);
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        check_eq({name, "_early_valid"}, bus.out_valid, 0);
        @(negedge clk);
        check_eq({name, "_out_valid"}, bus.out_valid, 1);
        check_eq({name, "_out_exponent"}, bus.out_exponent, ee);
        check_eq({name, "_out_fraction"}, bus.out_fraction, ef);
        check_eq({name, "_out_tag"}, bus.out_tag, t);
        check_eq({name, "_out_source"}, bus.out_source, src);
        @(posedge clk); #1;
    endtask

    logic       ra, rb;
    logic [3:0] t4_tags [6] = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
    logic       t5_ar   [7] = '{1, 1, 0, 0, 0, 0, 1};
    logic       t5_ov   [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [3:0] t5_ot   [10] = '{0, 0, 4, 4, 4, 4, 4, 5, 6, 0};
    int         taken;

    initial begin
        bus.a_valid = 0; bus.a_exponent = '0; bus.a_fraction = '0; bus.a_tag = '0;
        bus.b_valid = 0; bus.b_exponent = '0; bus.b_fraction = '0; bus.b_tag = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_a_ready", bus.a_ready, 0);
        check_eq("rst_b_ready", bus.b_ready, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_single("t1_a_carry", 0, 10'd100, 49'h1_0000_0000_0000, 4'd3, 10'd101, 49'h0_8000_0000_0000);
        run_single("t2_b_norm", 1, 10'd50, 49'h0_8000_0000_0001, 4'd7, 10'd50, 49'h0_8000_0000_0001);
        run_single("t3_a_shift2", 0, 10'd20, 49'h0_2000_0000_0000, 4'd5, 10'd18, 49'h0_8000_0000_0000);
        run_single("t3_a_zero", 0, 10'd30, 49'h0_0000_0000_0000, 4'd6, 10'd6, 49'h0_0000_0000_0000);
        run_single("t3_b_wrapdn", 1, 10'd0, 49'h0_2000_0000_0000, 4'd2, 10'd1022, 49'h0_8000_0000_0000);
        run_single("t3_b_wrapup", 1, 10'd1023, 49'h1_8000_0000_0001, 4'd8, 10'd0, 49'h0_C000_0000_0000);

        // Both requesters busy: last grant was B, so A leads.
        bus.a_valid = 1; bus.a_tag = 4'd1; bus.a_exponent = 10'd1; bus.a_fraction = 49'h0_8000_0000_0000;
        bus.b_valid = 1; bus.b_tag = 4'd9; bus.b_exponent = 10'd9; bus.b_fraction = 49'h0_8000_0000_0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 6) begin
                check_eq("t4_a_ready", bus.a_ready, (c % 2) == 0);
                check_eq("t4_b_ready", bus.b_ready, (c % 2) == 1);
            end
            if (c >= 2 && c < 8) begin
                check_eq("t4_out_valid", bus.out_valid, 1);
                check_eq("t4_out_tag", bus.out_tag, t4_tags[c-2]);
                check_eq("t4_out_source", bus.out_source, (c % 2) == 1);
                check_eq("t4_out_exponent", bus.out_exponent, {6'd0, t4_tags[c-2]});
            end else if (c >= 8) begin
                check_eq("t4_out_idle", bus.out_valid, 0);
            end
            ra = bus.a_ready;
            rb = bus.b_ready;
            @(posedge clk); #1;
            if (ra) begin
                bus.a_tag = bus.a_tag + 4'd1;
                bus.a_exponent = {6'd0, bus.a_tag};
                if (bus.a_tag == 4'd4) bus.a_valid = 0;
            end
            if (rb) begin
                bus.b_tag = bus.b_tag + 4'd1;
                bus.b_exponent = {6'd0, bus.b_tag};
                if (bus.b_tag == 4'd12) bus.b_valid = 0;
            end
        end

        // Three A ops into a stalled output for four cycles.
        bus.a_valid = 0; bus.b_valid = 0;
        bus.out_ready = 0;
        bus.a_valid = 1; bus.a_tag = 4'd4; bus.a_exponent = 10'd40; bus.a_fraction = 49'h1_0000_0000_0000;
        taken = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 7) check_eq("t5_a_ready", bus.a_ready, t5_ar[c]);
            check_eq("t5_out_valid", bus.out_valid, t5_ov[c]);
            if (t5_ov[c]) begin
                check_eq("t5_out_tag", bus.out_tag, t5_ot[c]);
                check_eq("t5_out_exponent", bus.out_exponent, {6'd0, t5_ot[c]} + 10'd37);
                check_eq("t5_out_fraction", bus.out_fraction, 49'h0_8000_0000_0000);
            end
            ra = bus.a_ready && bus.a_valid;
            @(posedge clk); #1;
            if (c == 5) bus.out_ready = 1;
            if (ra) begin
                taken++;
                bus.a_tag = bus.a_tag + 4'd1;
                bus.a_exponent = bus.a_exponent + 10'd1;
                if (taken == 3) bus.a_valid = 0;
            end
        end
        check_eq("t5_all_taken", taken, 3);

        // Fill both stages, then reset between clock edges.
        bus.out_ready = 0;
        bus.a_valid = 1; bus.a_tag = 4'd1; bus.a_exponent = 10'd5; bus.a_fraction = 49'h0_8000_0000_0000;
        @(posedge clk); #1;
        bus.a_tag = 4'd2;
        @(posedge clk); #1;
        bus.a_valid = 0;
        @(negedge clk);
        check_eq("t6_full_out_valid", bus.out_valid, 1);
        check_eq("t6_full_a_ready", bus.a_ready, 0);
        #2 reset_n = 1'b0;
        #1 check_eq("t6_async_out_valid", bus.out_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1;
        bus.a_valid = 1; bus.a_tag = 4'd7; bus.a_exponent = 10'd70; bus.a_fraction = 49'h0_8000_0000_0000;
        bus.b_valid = 1; bus.b_tag = 4'd12; bus.b_exponent = 10'd12; bus.b_fraction = 49'h0_4000_0000_0000;
        #1;
        check_eq("t6_tie_a_ready", bus.a_ready, 1);
        check_eq("t6_tie_b_ready", bus.b_ready, 0);
        @(posedge clk); #1;
        bus.a_valid = 0;
        @(negedge clk);
        check_eq("t6_b_ready", bus.b_ready, 1);
        check_eq("t6_lat_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.b_valid = 0;
        @(negedge clk);
        check_eq("t6_out1_valid", bus.out_valid, 1);
        check_eq("t6_out1_tag", bus.out_tag, 4'd7);
        check_eq("t6_out1_source", bus.out_source, 0);
        @(negedge clk);
        check_eq("t6_out2_valid", bus.out_valid, 1);
        check_eq("t6_out2_tag", bus.out_tag, 4'd12);
        check_eq("t6_out2_source", bus.out_source, 1);
        check_eq("t6_out2_exponent", bus.out_exponent, 10'd11);
        check_eq("t6_out2_fraction", bus.out_fraction, 49'h0_8000_0000_0000);
        @(negedge clk);
        check_eq("t6_drain", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
